mult_hilo_ctrl: RTL and testbench

//  Sits between the decode/issue stage and the iterative signed multiplier.

---
 rtl/mult_hilo_ctrl_pkg.sv | 21 ++
 rtl/mult_hilo_ctrl_if.sv | 37 +++
 rtl/mult_hilo_ctrl.sv | 131 +++++++++++++
 tb/tb_mult_hilo_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_hilo_ctrl_pkg.sv
// Shared opcodes, FSM encoding and default timing for the HI/LO controller.
// Imported by the controller and by the handshake interfaces.
package mult_hilo_ctrl_pkg;

  localparam logic [2:0] OP_MULT = 3'd0;
  localparam logic [2:0] OP_MTHI = 3'd1;
  localparam logic [2:0] OP_MTLO = 3'd2;
  localparam logic [2:0] OP_MFHI = 3'd3;
  localparam logic [2:0] OP_MFLO = 3'd4;

  localparam int TIMEOUT_DEF = 40;
  localparam int DRAIN_DEF   = 40;

  typedef enum logic [1:0] {
    S_DRAIN = 2'd0,
    S_IDLE  = 2'd1,
    S_START = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

endpackage

// File: rtl/mult_hilo_ctrl_if.sv
// Issue-side op/read bus and multiplier start/done bus.
// Master drives the request fields on each bus.
interface hilo_op_if;
  logic        op_valid;
  logic        op_ready;
  logic [2:0]  op_code;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        rd_valid;
  logic [31:0] rd_data;

  modport master (
    output op_valid, op_code, op_a, op_b,
    input  op_ready, rd_valid, rd_data
  );
  modport slave (
    input  op_valid, op_code, op_a, op_b,
    output op_ready, rd_valid, rd_data
  );
endinterface

interface hilo_mul_if;
  logic        mult_begin;
  logic [31:0] mult_op1;
  logic [31:0] mult_op2;
  logic [63:0] product;
  logic        mult_end;

  modport master (
    output mult_begin, mult_op1, mult_op2,
    input  product, mult_end
  );
  modport slave (
    input  mult_begin, mult_op1, mult_op2,
    output product, mult_end
  );
endinterface

// File: rtl/mult_hilo_ctrl.sv
// HI/LO register file and sequencer for the iterative signed multiplier.
// Stalls issue during a multiply and recovers from a hung multiplier.
module mult_hilo_ctrl
  import mult_hilo_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int DRAIN   = DRAIN_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  hilo_op_if.slave    op,
  hilo_mul_if.master  mul,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        err_timeout
);

  state_t      state_q, state_d;
  logic [7:0]  drain_q, drain_d;
  logic [7:0]  wait_q, wait_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        rdv_q, rdv_d;
  logic [31:0] rdd_q, rdd_d;
  logic [31:0] op1_q, op1_d;
  logic [31:0] op2_q, op2_d;
  logic        err_q, err_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_DRAIN;
      drain_q <= '0;
      wait_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      rdv_q   <= 1'b0;
      rdd_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      wait_q  <= wait_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      rdv_q   <= rdv_d;
      rdd_q   <= rdd_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    wait_d  = wait_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    rdv_d   = 1'b0;
    rdd_d   = rdd_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    err_d   = err_q;
    unique case (state_q)
      S_DRAIN: begin
        if (drain_q == 8'(DRAIN - 1)) begin
          state_d = S_IDLE;
          drain_d = '0;
        end else begin
          drain_d = drain_q + 8'd1;
        end
      end
      S_IDLE: begin
        if (op.op_valid) begin
          unique case (1'b1)
            (op.op_code == OP_MULT): begin
              op1_d   = op.op_a;
              op2_d   = op.op_b;
              state_d = S_START;
            end
            (op.op_code == OP_MTHI): hi_d = op.op_a;
            (op.op_code == OP_MTLO): lo_d = op.op_a;
            (op.op_code == OP_MFHI): begin
              rdd_d = hi_q;
              rdv_d = 1'b1;
            end
            (op.op_code == OP_MFLO): begin
              rdd_d = lo_q;
              rdv_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      S_START: begin
        state_d = S_WAIT;
        wait_d  = '0;
      end
      S_WAIT: begin
        if (mul.mult_end) begin
          hi_d    = mul.product[63:32];
          lo_d    = mul.product[31:0];
          state_d = S_IDLE;
        end else if (wait_q == 8'(TIMEOUT - 1)) begin
          // Hung multiplier: give it a drain window before new work.
          err_d   = 1'b1;
          drain_d = '0;
          state_d = S_DRAIN;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      default: state_d = S_DRAIN;
    endcase
  end

  assign op.op_ready    = (state_q == S_IDLE);
  assign op.rd_valid    = rdv_q;
  assign op.rd_data     = rdd_q;
  assign mul.mult_begin = (state_q == S_START);
  assign mul.mult_op1   = op1_q;
  assign mul.mult_op2   = op2_q;
  assign hi             = hi_q;
  assign lo             = lo_q;
  assign busy           = (state_q != S_IDLE);
  assign err_timeout    = err_q;

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Directed bench for mult_hilo_ctrl with a 34-cycle multiplier model.
// Read results and products are queued at issue and checked on output.
module tb_mult_hilo_ctrl;
  import mult_hilo_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic [31:0] hi, lo;
  logic        busy, err_timeout;

  hilo_op_if  opi();
  hilo_mul_if mi();

  mult_hilo_ctrl dut (
    .clk         (clk),
    .resetn      (resetn),
    .op          (opi),
    .mul         (mi),
    .hi          (hi),
    .lo          (lo),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  // Multiplier model: no reset, samples begin, done pulse 34 cycles later.
  logic [31:0] ma = '0, mb = '0;
  int          mcnt = 0;
  logic        stub_dead = 1'b0;
  logic [63:0] prod = '0;
  logic        mend = 1'b0;

  always @(posedge clk) begin
    mend <= 1'b0;
    if (mi.mult_begin) begin
      ma   <= mi.mult_op1;
      mb   <= mi.mult_op2;
      mcnt <= 34;
    end else if (mcnt != 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1 && !stub_dead) begin
        mend <= 1'b1;
        prod <= $signed({{32{ma[31]}}, ma}) * $signed({{32{mb[31]}}, mb});
      end
    end
  end

  assign mi.product  = prod;
  assign mi.mult_end = mend;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_rd = -10;
  int prev_rd = -20;
  logic [31:0] rq[$];
  logic [63:0] hq[$];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic mon();
    logic [31:0] e;
    if (opi.rd_valid) begin
      if (rq.size() == 0) begin
        chk("rd_stray", 1, 0);
      end else begin
        e = rq.pop_front();
        chk("rd_data", opi.rd_data, e);
        prev_rd = last_rd;
        last_rd = cyc;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    mon();
  endtask

  task automatic issue(input logic [2:0] c, input logic [31:0] a,
                       input logic [31:0] b, output int wt);
    opi.op_valid = 1'b1;
    opi.op_code  = c;
    opi.op_a     = a;
    opi.op_b     = b;
    wt = 0;
    while (!opi.op_ready && wt < 200) begin
      wt++;
      step();
    end
    step();
    opi.op_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    logic [63:0] e;
    n = 0;
    while (!opi.op_ready && n < 200) begin
      n++;
      step();
    end
    chk({tag, "_idle"}, opi.op_ready, 1);
    e = (hq.size() != 0) ? hq.pop_front() : 64'hDEAD;
    chk({tag, "_hi"}, hi, e[63:32]);
    chk({tag, "_lo"}, lo, e[31:0]);
  endtask

  initial begin
    int n, nb, bg, w;
    opi.op_valid = 1'b0;
    opi.op_code  = '0;
    opi.op_a     = '0;
    opi.op_b     = '0;

    #2 resetn = 1'b0;
    #1;
    chk("rst_ready", opi.op_ready, 0);
    chk("rst_hilo", {hi, lo}, 0);
    chk("rst_rdv", opi.rd_valid, 0);
    chk("rst_rdd", opi.rd_data, 0);
    chk("rst_begin", mi.mult_begin, 0);
    chk("rst_ops", {mi.mult_op1, mi.mult_op2}, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_busy", busy, 1);
    step();
    step();
    resetn = 1'b1;
    n = 0;
    while (!opi.op_ready && n < 100) begin
      n++;
      step();
    end
    chk("drain_len", n, DRAIN_DEF);

    // 1: 3 * -5
    hq.push_back(64'hFFFFFFFF_FFFFFFF1);
    issue(OP_MULT, 32'd3, 32'hFFFFFFFB, w);
    chk("t1_begin", mi.mult_begin, 1);
    nb = 0;
    bg = 0;
    while (busy && nb < 200) begin
      nb++;
      if (mi.mult_begin) bg++;
      if (nb == 20) chk("t1_op1_hold", mi.mult_op1, 32'd3);
      step();
    end
    chk("t1_busy_len", nb, 36);
    chk("t1_begin_cnt", bg, 1);
    wait_idle("t1");

    // 2: min * min, then MFHI
    hq.push_back(64'h40000000_00000000);
    issue(OP_MULT, 32'h80000000, 32'h80000000, w);
    wait_idle("t2");
    rq.push_back(32'h40000000);
    issue(OP_MFHI, '0, '0, w);
    chk("t2_rd_empty", rq.size(), 0);

    // 3: MTHI/MTLO then back-to-back reads, plus a NOP
    issue(OP_MTHI, 32'h12345678, '0, w);
    issue(OP_MTLO, 32'h9ABCDEF0, '0, w);
    rq.push_back(32'h9ABCDEF0);
    issue(OP_MFLO, '0, '0, w);
    rq.push_back(32'h12345678);
    issue(OP_MFHI, '0, '0, w);
    chk("t3_b2b", last_rd - prev_rd, 1);
    chk("t3_rd_empty", rq.size(), 0);
    issue(3'd7, 32'hFFFFFFFF, '0, w);
    step();
    chk("t3_nop", {hi, lo}, 64'h12345678_9ABCDEF0);

    // 4: MULT followed by a held MFLO
    hq.push_back(64'h00000001_00010000);
    issue(OP_MULT, 32'h00010000, 32'h00010001, w);
    rq.push_back(32'h00010000);
    issue(OP_MFLO, '0, '0, w);
    chk("t4_stall", w, 36);
    chk("t4_rd_empty", rq.size(), 0);
    wait_idle("t4");

    // 5: reset in the middle of a multiply
    issue(OP_MULT, 32'd9, 32'd9, w);
    for (int i = 0; i < 10; i++) step();
    resetn = 1'b0;
    #1;
    chk("t5_rst_hilo", {hi, lo}, 0);
    chk("t5_rst_ready", opi.op_ready, 0);
    step();
    step();
    resetn = 1'b1;
    n = 0;
    while (!opi.op_ready && n < 100) begin
      n++;
      step();
    end
    chk("t5_drain", n, DRAIN_DEF);
    chk("t5_stray", {hi, lo}, 0);
    hq.push_back(64'h00000000_0000002A);
    issue(OP_MULT, 32'd7, 32'd6, w);
    wait_idle("t5");

    // 6: multiplier never finishes
    stub_dead = 1'b1;
    issue(OP_MULT, 32'd5, 32'd5, w);
    n = 0;
    while (!err_timeout && n < 200) begin
      n++;
      step();
    end
    chk("t6_to_len", n, TIMEOUT_DEF + 1);
    chk("t6_hilo", {hi, lo}, 64'h00000000_0000002A);
    chk("t6_ready", opi.op_ready, 0);
    n = 0;
    while (!opi.op_ready && n < 100) begin
      n++;
      step();
    end
    chk("t6_drain", n, DRAIN_DEF);
    chk("t6_sticky", err_timeout, 1);
    chk("t6_busy", busy, 0);
    stub_dead = 1'b0;

    step();
    chk("end_rq", rq.size(), 0);
    chk("end_hq", hq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
